// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding encoding,
// in-flight writer entry layout and the supported load-latency range.
package pipe_pkg;

  localparam int FWD_REGFILE  = 0;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 3;
  // Widest register index any instance may use; narrower indices are zero-extended.
  localparam int RD_MAX_W     = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } inflight_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-side bundle of the hazard controller: decoded ID fields, EX/MEM status
// inputs and the stage enables / forwarding selects it returns.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_is_load;
  logic              ex_redirect;
  logic              mem_busy;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              pipe_freeze;
  logic [SEL_W-1:0]  fwd_sel_rs1;
  logic [SEL_W-1:0]  fwd_sel_rs2;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_is_load, ex_redirect, mem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           fwd_sel_rs1, fwd_sel_rs2
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_is_load, ex_redirect, mem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
           fwd_sel_rs1, fwd_sel_rs2
  );
endinterface

// File: rtl/pipe_hazard_ctrl_inflight_table.sv
// Shift table of in-flight writers (EX, M1..M_L, WB) with a youngest-first
// match encoder for the two ID source operands.
module inflight_table
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int POS_W    = $clog2(LOAD_LAT + 2)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   push_valid,
  input  logic [REG_AW-1:0]      push_rd,
  input  logic                   push_is_load,
  input  logic [1:0][REG_AW-1:0] src_idx,
  input  logic [1:0]             src_use,
  output logic [1:0]             src_hit,
  output logic [1:0][POS_W-1:0]  src_pos,
  output logic [1:0]             src_is_load
);

  localparam int DEPTH = LOAD_LAT + 2;

  inflight_entry_t tbl [DEPTH];
  inflight_entry_t push_e;

  // A write to x0 is architecturally a no-op, so it never occupies a slot.
  always_comb begin
    push_e         = '0;
    push_e.valid   = push_valid && (push_rd != '0);
    push_e.rd      = RD_MAX_W'(push_rd);
    push_e.is_load = push_is_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < DEPTH; p++) tbl[p] <= '0;
    end else if (shift_en) begin
      tbl[0] <= push_e;
      for (int p = 1; p < DEPTH; p++) tbl[p] <= tbl[p-1];
    end
  end

  // Scan oldest to youngest so the lowest position overwrites any older hit.
  always_comb begin
    src_hit     = '0;
    src_pos     = '0;
    src_is_load = '0;
    for (int s = 0; s < 2; s++) begin
      for (int p = DEPTH - 1; p >= 0; p--) begin
        if (src_use[s] && (src_idx[s] != '0) && tbl[p].valid &&
            (tbl[p].rd == RD_MAX_W'(src_idx[s]))) begin
          src_hit[s]     = 1'b1;
          src_pos[s]     = POS_W'(p);
          src_is_load[s] = tbl[p].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside ID: stage enables, flush/bubble/freeze and registered
// forwarding selects. HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(LOAD_LAT + 2)
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic [1:0][REG_AW-1:0] src_idx;
  logic [1:0]             src_use;
  logic [1:0]             src_hit;
  logic [1:0][SEL_W-1:0]  src_pos;
  logic [1:0]             src_is_load;
  logic                   load_use;
  logic                   issue;
  logic [1:0][SEL_W-1:0]  next_sel;

  assign src_idx[0] = hz.id_rs1;
  assign src_idx[1] = hz.id_rs2;
  assign src_use[0] = hz.id_use_rs1;
  assign src_use[1] = hz.id_use_rs2;

  inflight_table #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT),
    .POS_W    (SEL_W)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (!hz.mem_busy),
    .push_valid   (issue && hz.id_reg_write),
    .push_rd      (hz.id_rd),
    .push_is_load (hz.id_is_load),
    .src_idx      (src_idx),
    .src_use      (src_use),
    .src_hit      (src_hit),
    .src_pos      (src_pos),
    .src_is_load  (src_is_load)
  );

  // A load whose data is still short of the last M stage cannot be forwarded yet.
  always_comb begin
    load_use = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (src_hit[s] && src_is_load[s] && (src_pos[s] < SEL_W'(LOAD_LAT)))
        load_use = 1'b1;
    end
    load_use = load_use && hz.id_valid;
  end

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    hz.pipe_freeze  = 1'b0;
    issue           = 1'b0;
    if (reset) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (hz.mem_busy) begin
      hz.pipe_freeze  = 1'b1;
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
    end else if (hz.ex_redirect) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_bubble = 1'b1;
    end else if (load_use) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end else begin
      issue = hz.id_valid;
    end
  end

  // A WB-position hit reads through the write-first regfile, so it selects 0.
  always_comb begin
    next_sel = '0;
    for (int s = 0; s < 2; s++) begin
      next_sel[s] = SEL_W'(FWD_REGFILE);
      if (issue && src_hit[s] && (src_pos[s] <= SEL_W'(LOAD_LAT)))
        next_sel[s] = src_pos[s] + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hz.fwd_sel_rs1 <= SEL_W'(FWD_REGFILE);
      hz.fwd_sel_rs2 <= SEL_W'(FWD_REGFILE);
    end else if (!hz.mem_busy) begin
      hz.fwd_sel_rs1 <= next_sel[0];
      hz.fwd_sel_rs2 <= next_sel[1];
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hz.mem_busy) begin
      if (hz.ex_redirect)  flush_cnt <= flush_cnt + 32'd1;
      else if (load_use)   stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
